// File: rtl/enc8b10b_pkg.sv
// Shared types, constants and helpers for the 8b/10b transmit controller.
// Defining ENC_TX_CTRL_ALIGN_EN adds the ALIGN state to the FSM enum.
package enc8b10b_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_DATA
`ifdef ENC_TX_CTRL_ALIGN_EN
        , ST_ALIGN
`endif
    } tx_state_e;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic       RD_NEG = 1'b0;
    localparam logic       RD_POS = 1'b1;

    // Only K28.y and the four Kx.7 codes have legal encodings.
    function automatic logic is_valid_k(input logic [7:0] b);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                (x == 5'd29) || (x == 5'd30)));
    endfunction

endpackage

// File: rtl/enc_8b10b_core.sv
// Combinational 8b/10b encoder: 5b6b then 3b4b, disparity chained between them.
// Output bit order is abcdei fghj with a in the MSB.
module enc_8b10b_core
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       rd_i,
    output logic [9:0] sym_o,
    output logic       rd_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] code6;
    logic [5:0] six;
    logic [3:0] code4;
    logic [3:0] four;
    logic       rd6;
    logic       bal6;
    logic       bal4;
    logic       alt;

    assign x = data_i[4:0];
    assign y = data_i[7:5];

    // Tables hold the RD- code; unbalanced codes (and D.7 / D.x.3) invert under RD+.
    always_comb begin
        case (x)
            5'd0:    code6 = 6'b100111;
            5'd1:    code6 = 6'b011101;
            5'd2:    code6 = 6'b101101;
            5'd3:    code6 = 6'b110001;
            5'd4:    code6 = 6'b110101;
            5'd5:    code6 = 6'b101001;
            5'd6:    code6 = 6'b011001;
            5'd7:    code6 = 6'b111000;
            5'd8:    code6 = 6'b111001;
            5'd9:    code6 = 6'b100101;
            5'd10:   code6 = 6'b010101;
            5'd11:   code6 = 6'b110100;
            5'd12:   code6 = 6'b001101;
            5'd13:   code6 = 6'b101100;
            5'd14:   code6 = 6'b011100;
            5'd15:   code6 = 6'b010111;
            5'd16:   code6 = 6'b011011;
            5'd17:   code6 = 6'b100011;
            5'd18:   code6 = 6'b010011;
            5'd19:   code6 = 6'b110010;
            5'd20:   code6 = 6'b001011;
            5'd21:   code6 = 6'b101010;
            5'd22:   code6 = 6'b011010;
            5'd23:   code6 = 6'b111010;
            5'd24:   code6 = 6'b110011;
            5'd25:   code6 = 6'b100110;
            5'd26:   code6 = 6'b010110;
            5'd27:   code6 = 6'b110110;
            5'd28:   code6 = 6'b001110;
            5'd29:   code6 = 6'b101110;
            5'd30:   code6 = 6'b011110;
            default: code6 = 6'b101011;
        endcase
        if (k_i && (x == 5'd28)) begin
            code6 = 6'b001111;
        end
        bal6 = ($countones(code6) == 3);
        six  = ((rd_i == RD_POS) && (!bal6 || (x == 5'd7))) ? ~code6 : code6;
        rd6  = bal6 ? rd_i : ~rd_i;

        alt = k_i ||
              ((rd6 == RD_NEG) && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ((rd6 == RD_POS) && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

        case (y)
            3'd0:    code4 = 4'b1011;
            3'd1:    code4 = 4'b1001;
            3'd2:    code4 = 4'b0101;
            3'd3:    code4 = 4'b1100;
            3'd4:    code4 = 4'b1101;
            3'd5:    code4 = 4'b1010;
            3'd6:    code4 = 4'b0110;
            default: code4 = alt ? 4'b0111 : 4'b1110;
        endcase
        bal4 = ($countones(code4) == 2);
        four = ((rd6 == RD_POS) && (!bal4 || (y == 3'd3))) ? ~code4 : code4;
        // K28 neutral trailers flip after a negative 6b half, unlike data.
        if (k_i && (rd6 == RD_NEG) && bal4 && (y != 3'd3)) begin
            four = ~four;
        end
        rd_o  = bal4 ? rd6 : ~rd6;
        sym_o = {six, four};
    end

endmodule

// File: rtl/enc_tx_ctrl.sv
// 8b/10b transmit controller: SYNC comma burst, then data with idle commas.
// Defining ENC_TX_CTRL_ALIGN_EN adds periodic alignment commas via the ALIGN state.
module enc_tx_ctrl
    import enc8b10b_pkg::*;
#(
    parameter int SYNC_LEN     = 4,
    parameter int ALIGN_PERIOD = 256
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sym_en_i,
    input  logic       in_valid_i,
    input  logic       in_k_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic [9:0] out_sym_o,
    output logic       out_rd_o,
    output logic       out_kerr_o,
    output logic       link_up_o
);

    localparam int            SW        = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);

    if ((SYNC_LEN < 1) || (ALIGN_PERIOD < 2)) begin : g_param_check
        $error("enc_tx_ctrl: SYNC_LEN must be >= 1 and ALIGN_PERIOD >= 2");
    end

    tx_state_e     state_q;
    logic [SW-1:0] sync_cnt_q;
    logic [9:0]    out_sym_q;
    logic          rd_q;
    logic          kerr_q;
    logic          link_up_q;
    logic          align_due;
    logic          transfer;
    logic          bad_k;
    logic [7:0]    enc_data;
    logic          enc_k;
    logic [9:0]    enc_sym;
    logic          enc_rd;

`ifdef ENC_TX_CTRL_ALIGN_EN
    localparam int            AW         = $clog2(ALIGN_PERIOD);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_PERIOD - 1);

    logic [AW-1:0] align_cnt_q;
    logic [AW-1:0] align_cnt_d;
    logic          comma_out;

    assign align_due   = (align_cnt_q == ALIGN_LAST);
    assign align_cnt_d = align_cnt_q + AW'(1);
    assign comma_out   = enc_k && (enc_data == K28_5);
`else
    assign align_due = 1'b0;
`endif

    assign in_ready_o = sym_en_i && (state_q == ST_DATA) && !align_due;
    assign transfer   = in_valid_i && in_ready_o;
    assign bad_k      = transfer && in_k_i && !is_valid_k(in_data_i);

    // Anything other than an accepted legal byte goes out as a K28.5 comma.
    always_comb begin
        enc_data = K28_5;
        enc_k    = 1'b1;
        if (transfer && !bad_k) begin
            enc_data = in_data_i;
            enc_k    = in_k_i;
        end
    end

    enc_8b10b_core u_core (
        .data_i (enc_data),
        .k_i    (enc_k),
        .rd_i   (rd_q),
        .sym_o  (enc_sym),
        .rd_o   (enc_rd)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_SYNC;
            sync_cnt_q  <= '0;
            out_sym_q   <= '0;
            rd_q        <= RD_NEG;
            kerr_q      <= 1'b0;
            link_up_q   <= 1'b0;
`ifdef ENC_TX_CTRL_ALIGN_EN
            align_cnt_q <= '0;
`endif
        end else begin
            kerr_q <= bad_k;
            if (sym_en_i) begin
                out_sym_q <= enc_sym;
                rd_q      <= enc_rd;
                case (state_q)
                    ST_SYNC: begin
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_q    <= ST_DATA;
                            link_up_q  <= 1'b1;
                            sync_cnt_q <= '0;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + SW'(1);
                        end
                    end
                    ST_DATA: begin
`ifdef ENC_TX_CTRL_ALIGN_EN
                        // Entering ALIGN as the count lands makes the comma the next slot.
                        if (comma_out) begin
                            align_cnt_q <= '0;
                        end else begin
                            align_cnt_q <= align_cnt_d;
                            if (align_cnt_d == ALIGN_LAST) begin
                                state_q <= ST_ALIGN;
                            end
                        end
`endif
                    end
`ifdef ENC_TX_CTRL_ALIGN_EN
                    ST_ALIGN: begin
                        align_cnt_q <= '0;
                        state_q     <= ST_DATA;
                    end
`endif
                    default: state_q <= ST_SYNC;
                endcase
            end
        end
    end

    assign out_sym_o  = out_sym_q;
    assign out_rd_o   = rd_q;
    assign out_kerr_o = kerr_q;
    assign link_up_o  = link_up_q;

endmodule

// File: tb/tb_enc_tx_ctrl.sv
// Directed self-checking bench for enc_tx_ctrl with hand-computed 8b/10b symbols.
// The alignment-comma section only runs when ENC_TX_CTRL_ALIGN_EN is defined.
module tb_enc_tx_ctrl;

    localparam logic [9:0] K285_NEG = 10'b0011111010;
    localparam logic [9:0] K285_POS = 10'b1100000101;
    localparam logic [9:0] D21_5    = 10'b1010101010;
    localparam logic [9:0] D10_2    = 10'b0101010101;

    logic       clock;
    logic       rstN;
    logic       symEn;
    logic       inValid;
    logic       inK;
    logic [7:0] inData;
    logic       inReady;
    logic [9:0] outSym;
    logic       outRd;
    logic       outKerr;
    logic       linkUp;
    logic       readySeen;
    int         checkCount;
    int         errorCount;

    enc_tx_ctrl #(
        .SYNC_LEN     (4),
        .ALIGN_PERIOD (8)
    ) dut (
        .clk_i      (clock),
        .rst_n_i    (rstN),
        .sym_en_i   (symEn),
        .in_valid_i (inValid),
        .in_k_i     (inK),
        .in_data_i  (inData),
        .in_ready_o (inReady),
        .out_sym_o  (outSym),
        .out_rd_o   (outRd),
        .out_kerr_o (outKerr),
        .link_up_o  (linkUp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One slot: drive inputs, capture the combinational ready, then step past the edge.
    task automatic applyStimulus(input logic en, input logic valid, input logic k,
                                 input logic [7:0] data);
        symEn   = en;
        inValid = valid;
        inK     = k;
        inData  = data;
        #1;
        readySeen = inReady;
        @(posedge clock);
        #1;
    endtask

    task automatic runSync(input logic valid);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, valid, 1'b0, 8'hB5);
            checkOutput("syncReady", 10'(readySeen), 10'd0);
            checkOutput("syncSym", outSym, (i % 2 == 0) ? K285_NEG : K285_POS);
            checkOutput("syncLink", 10'(linkUp), 10'(i == 3));
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rstN    = 1'b0;
        symEn   = 1'b0;
        inValid = 1'b0;
        inK     = 1'b0;
        inData  = 8'h00;
        readySeen = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        symEn = 1'b1;
        #1;
        checkOutput("rstSym", outSym, 10'd0);
        checkOutput("rstRd", 10'(outRd), 10'd0);
        checkOutput("rstKerr", 10'(outKerr), 10'd0);
        checkOutput("rstLink", 10'(linkUp), 10'd0);
        checkOutput("rstReady", 10'(inReady), 10'd0);
        rstN = 1'b1;

        $display("[TB] sync sequence with a byte already waiting");
        runSync(1'b1);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("idle1Ready", 10'(readySeen), 10'd1);
        checkOutput("idle1Sym", outSym, K285_NEG);
        checkOutput("idle1Rd", 10'(outRd), 10'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("idle2Sym", outSym, K285_POS);
        checkOutput("idle2Rd", 10'(outRd), 10'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hB5);
        checkOutput("d21_5Ready", 10'(readySeen), 10'd1);
        checkOutput("d21_5Sym", outSym, D21_5);
        checkOutput("d21_5Rd", 10'(outRd), 10'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hF1);
        checkOutput("holdReady", 10'(readySeen), 10'd0);
        checkOutput("holdSym", outSym, D21_5);
        checkOutput("holdRd", 10'(outRd), 10'd0);

        // 1000110111 carries six ones, so disparity ends positive.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hF1);
        checkOutput("d17_7Ready", 10'(readySeen), 10'd1);
        checkOutput("d17_7Sym", outSym, 10'b1000110111);
        checkOutput("d17_7Rd", 10'(outRd), 10'd1);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("badKReady", 10'(readySeen), 10'd1);
        checkOutput("badKSym", outSym, K285_POS);
        checkOutput("badKRd", 10'(outRd), 10'd0);
        checkOutput("badKPulse", 10'(outKerr), 10'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("badKClear", 10'(outKerr), 10'd0);
        checkOutput("badKHold", outSym, K285_POS);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h1C);
        checkOutput("k28_0Sym", outSym, 10'b0011110100);
        checkOutput("k28_0Rd", 10'(outRd), 10'd0);
        checkOutput("k28_0Kerr", 10'(outKerr), 10'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("d0_0NegSym", outSym, 10'b1001110100);
        checkOutput("d0_0NegRd", 10'(outRd), 10'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'hF7);
        checkOutput("k23_7Sym", outSym, 10'b1110101000);
        checkOutput("k23_7Rd", 10'(outRd), 10'd0);
        checkOutput("k23_7Kerr", 10'(outKerr), 10'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("idle3Sym", outSym, K285_NEG);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("d0_0PosSym", outSym, 10'b0110001011);
        checkOutput("d0_0PosRd", 10'(outRd), 10'd1);

        $display("[TB] reset in the middle of data traffic");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hB5);
        rstN  = 1'b0;
        symEn = 1'b1;
        #1;
        checkOutput("midRstSym", outSym, 10'd0);
        checkOutput("midRstRd", 10'(outRd), 10'd0);
        checkOutput("midRstLink", 10'(linkUp), 10'd0);
        checkOutput("midRstReady", 10'(inReady), 10'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            symEn = ~symEn;
            checkOutput("inRstSym", outSym, 10'd0);
        end
        rstN = 1'b1;
        runSync(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hB5);
        checkOutput("postRstReady", 10'(readySeen), 10'd1);
        checkOutput("postRstSym", outSym, D21_5);

`ifdef ENC_TX_CTRL_ALIGN_EN
        $display("[TB] periodic alignment commas under continuous traffic");
        rstN = 1'b0;
        #1;
        rstN = 1'b1;
        runSync(1'b0);
        begin
            int  byteIdx;
            logic isComma;
            byteIdx = 0;
            for (int slot = 0; slot < 24; slot++) begin
                applyStimulus(1'b1, 1'b1, 1'b0, (byteIdx % 2 == 1) ? 8'h4A : 8'hB5);
                if (slot % 8 == 7) begin
                    isComma = (outSym == K285_NEG) || (outSym == K285_POS);
                    checkOutput("alignReady", 10'(readySeen), 10'd0);
                    checkOutput("alignComma", 10'(isComma), 10'd1);
                end else begin
                    checkOutput("alignDataReady", 10'(readySeen), 10'd1);
                    checkOutput("alignDataSym", outSym, (byteIdx % 2 == 1) ? D10_2 : D21_5);
                    byteIdx++;
                end
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
